// File: rtl/fat32_dirent_sector_updater.sv
// FAT32 directory-sector read-modify-write sequencer.
// Reads one sector into a local byte buffer, overwrites NUM_ENTRIES consecutive
// 32-byte directory slots with the supplied entry bytes, then writes it back.
//
// Handshake summary: rd_start/wr_start are single-cycle pulses to the SD engine;
// every rd_valid cycle carries one sector byte (in order 0..SECTOR_BYTES-1);
// every wr_req cycle pulls one byte, returned with wr_valid exactly one cycle
// later; rd_done/wr_done close the respective phase. No back-pressure exists on
// either side, so the valids are strobes rather than valid/ready pairs.
module fat32_dirent_sector_updater #(
    parameter int SECTOR_BYTES = 512,
    parameter int NUM_ENTRIES  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [31:0]                dir_sector,
    input  logic [3:0]                 slot_index,
    input  logic [NUM_ENTRIES*256-1:0] entries,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic                       rd_start,
    output logic [31:0]                rd_addr,
    input  logic                       rd_valid,
    input  logic [7:0]                 rd_data,
    input  logic                       rd_done,
    output logic                       wr_start,
    output logic [31:0]                wr_addr,
    input  logic                       wr_req,
    output logic                       wr_valid,
    output logic [7:0]                 wr_data,
    input  logic                       wr_done,
    output logic [3:0]                 state_dbg
);

    localparam int AW          = $clog2(SECTOR_BYTES);
    localparam int PATCH_BYTES = NUM_ENTRIES * 32;
    localparam int KW          = $clog2(PATCH_BYTES);
    localparam logic [AW:0]   CNT_FULL   = (AW+1)'(SECTOR_BYTES);
    localparam logic [KW-1:0] PATCH_LAST = KW'(PATCH_BYTES - 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_CHECK   = 4'd1,
        S_RD_REQ  = 4'd2,
        S_RD_DATA = 4'd3,
        S_PATCH   = 4'd4,
        S_WR_REQ  = 4'd5,
        S_WR_DATA = 4'd6,
        S_FIN     = 4'd7,
        S_ERR     = 4'd8
    } state_t;

    state_t                     state;
    state_t                     state_nx;
    logic [31:0]                sector_q;
    logic [3:0]                 slot_q;
    logic [NUM_ENTRIES*256-1:0] entries_q;
    logic [AW:0]                rd_cnt;
    logic [AW:0]                wr_cnt;
    logic [KW-1:0]              k_cnt;
    logic [7:0]                 mem [0:SECTOR_BYTES-1];

    logic          rd_take;
    logic          wr_take;
    logic [AW:0]   rd_cnt_eff;
    logic [AW-1:0] patch_addr;
    logic [7:0]    patch_byte;
    logic          slot_overflow;

    // A read byte is stored only while the buffer still has room; extras are dropped.
    assign rd_take    = (state == S_RD_DATA) && rd_valid && (rd_cnt < CNT_FULL);
    assign wr_take    = (state == S_WR_DATA) && wr_req && (wr_cnt < CNT_FULL);
    // Byte count including a byte arriving in the same cycle as rd_done.
    assign rd_cnt_eff = rd_cnt + {{AW{1'b0}}, rd_take};
    assign patch_addr = AW'({slot_q, 5'd0}) + AW'(k_cnt);
    assign patch_byte = entries_q[{k_cnt, 3'b000} +: 8];
    assign slot_overflow = ({1'b0, slot_q} + 5'(NUM_ENTRIES)) > 5'd16;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (start) state_nx = S_CHECK;
            S_CHECK:   state_nx = slot_overflow ? S_ERR : S_RD_REQ;
            S_RD_REQ:  state_nx = S_RD_DATA;
            S_RD_DATA: if (rd_done) state_nx = (rd_cnt_eff == CNT_FULL) ? S_PATCH : S_ERR;
            S_PATCH:   if (k_cnt == PATCH_LAST) state_nx = S_WR_REQ;
            S_WR_REQ:  state_nx = S_WR_DATA;
            S_WR_DATA: if (wr_done) state_nx = S_FIN;
            S_FIN:     state_nx = S_IDLE;
            S_ERR:     state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        busy     = (state != S_IDLE);
        done     = (state == S_FIN);
        error    = (state == S_ERR);
        rd_start = (state == S_RD_REQ);
        wr_start = (state == S_WR_REQ);
    end

    assign rd_addr   = sector_q;
    assign wr_addr   = sector_q;
    assign state_dbg = state;

    // Request latch and phase counters; counters are rearmed in CHECK for each request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sector_q  <= '0;
            slot_q    <= '0;
            entries_q <= '0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            k_cnt     <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                sector_q  <= dir_sector;
                slot_q    <= slot_index;
                entries_q <= entries;
            end
            if (state == S_CHECK) begin
                rd_cnt <= '0;
                wr_cnt <= '0;
                k_cnt  <= '0;
            end else begin
                if (rd_take)            rd_cnt <= rd_cnt + 1'b1;
                if (wr_take)            wr_cnt <= wr_cnt + 1'b1;
                if (state == S_PATCH)   k_cnt  <= k_cnt + 1'b1;
            end
        end
    end

    // Sector buffer write port: read-phase fill or entry patch, never both.
    always_ff @(posedge clk) begin
        if (rd_take)
            mem[rd_cnt[AW-1:0]] <= rd_data;
        else if (state == S_PATCH)
            mem[patch_addr] <= patch_byte;
    end

    // Write-back read port: one buffer byte returned the cycle after each accepted wr_req.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_valid <= 1'b0;
            wr_data  <= '0;
        end else begin
            wr_valid <= wr_take;
            if (wr_take) wr_data <= mem[wr_cnt[AW-1:0]];
        end
    end

endmodule
